// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave backed by DEPTH words of on-chip memory, with byte/halfword lanes,
// configurable OKAY wait states and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int BYTES    = DATA_W / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [2:0] SIZE_MAX = 3'(ADDR_LSB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    function automatic logic [BYTES-1:0] f_lane_mask(input logic [2:0] size,
                                                      input logic [ADDR_LSB-1:0] lo);
        logic [BYTES-1:0] m;
        int first;
        int last;
        first = int'(lo);
        last  = first + int'(32'd1 << size);
        m     = '0;
        for (int b = 0; b < BYTES; b++) begin
            m[b] = (b >= first) && (b < last);
        end
        return m;
    endfunction

    function automatic logic f_misaligned(input logic [2:0] size,
                                          input logic [ADDR_LSB-1:0] lo);
        logic [ADDR_LSB-1:0] m;
        m = '0;
        for (int i = 0; i < ADDR_LSB; i++) begin
            m[i] = (i < int'(size));
        end
        return |(lo & m);
    endfunction

    function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [BYTES-1:0]  mask);
        logic [DATA_W-1:0] res;
        for (int b = 0; b < BYTES; b++) begin
            res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        end
        return res;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic              r_hreadyout;
    logic              r_hresp;
    logic [DATA_W-1:0] r_hrdata;
    logic [3:0]        r_cnt;
    logic              r_dp_valid;
    logic              r_dp_write;
    logic [IDX_W-1:0]  r_dp_idx;
    logic [BYTES-1:0]  r_dp_mask;

    logic [ADDR_W-1:0] w_word;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_accept;
    logic              w_commit;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_unused_ok;

    assign w_word   = HADDR >> ADDR_LSB;
    assign w_idx    = w_word[IDX_W-1:0];
    assign w_err    = (w_word >= ADDR_W'(DEPTH)) | (HSIZE > SIZE_MAX)
                    | f_misaligned(HSIZE, HADDR[ADDR_LSB-1:0]);
    // Only IDLE/ERR2 drive HREADYOUT high, so gating on it ignores anything offered mid data phase.
    assign w_accept = HSEL & HTRANS[1] & HREADY & r_hreadyout;
    assign w_commit = r_dp_valid & r_dp_write & r_hreadyout;

    // A write completing on the same edge that accepts a read of that word is forwarded into the read.
    assign w_rd_word = (w_commit && (r_dp_idx == w_idx))
                     ? f_merge(r_mem[w_idx], HWDATA, r_dp_mask)
                     : r_mem[w_idx];

    assign w_unused_ok = ^{HBURST, HTRANS[0]};

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;

    // Memory array: byte-lane write on the edge that completes an OKAY write data phase.
    always_ff @(posedge HCLK) begin
        if (w_commit) begin
            r_mem[r_dp_idx] <= f_merge(r_mem[r_dp_idx], HWDATA, r_dp_mask);
        end
    end

    // Transfer FSM with registered response, wait counter and data-phase context.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
            r_hrdata    <= '0;
            r_cnt       <= 4'd0;
            r_dp_valid  <= 1'b0;
            r_dp_write  <= 1'b0;
            r_dp_idx    <= '0;
            r_dp_mask   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_accept && !w_err) begin
                        r_dp_valid <= 1'b1;
                        r_dp_write <= HWRITE;
                        r_dp_idx   <= w_idx;
                        r_dp_mask  <= f_lane_mask(HSIZE, HADDR[ADDR_LSB-1:0]);
                        r_hrdata   <= HWRITE ? '0 : w_rd_word;
                        r_hresp    <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            r_state     <= ST_WAIT;
                            r_hreadyout <= 1'b0;
                            r_cnt       <= CNT_LOAD;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_hreadyout <= 1'b1;
                            r_cnt       <= 4'd0;
                        end
                    end else if (w_accept) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= 1'b1;
                        r_hrdata    <= '0;
                        r_dp_valid  <= 1'b0;
                        r_dp_write  <= 1'b0;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= 1'b0;
                        r_hrdata    <= '0;
                        r_dp_valid  <= 1'b0;
                        r_dp_write  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= 1'b0;
                    r_hrdata    <= '0;
                    r_dp_valid  <= 1'b0;
                    r_dp_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with no wait states and one with three,
// sharing the master signals and selected in turn.
module tb_ahb_lite_sram_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel;
    logic        sel3;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;

    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rdata0, rdata3;
    logic        rdy, resp;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;

    assign rdy   = sel3 ? rdy3   : rdy0;
    assign resp  = sel3 ? resp3  : resp0;
    assign rdata = sel3 ? rdata3 : rdata0;

    always #5 HCLK = ~HCLK;

    ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & ~sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy0),
        .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0)
    );

    ahb_lite_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel & sel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(rdy3),
        .HREADYOUT(rdy3), .HRESP(resp3), .HRDATA(rdata3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // Single transfer: address phase, then data phase until HREADYOUT, returning data/resp/low count.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd, output logic rs,
                        output int low);
        hsel   = 1'b1;
        haddr  = a;
        htrans = 2'b10;
        hwrite = w;
        hsize  = sz;
        step();
        hsel   = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = wd;
        low    = 0;
        while (rdy !== 1'b1 && low < 40) begin
            low++;
            step();
        end
        rd = rdata;
        rs = resp;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        rs;
        int          low;
        int          cyc;
        int          guard;
        logic [31:0] bexp [4];

        HRESETn = 1'b0;
        hsel = 1'b0; sel3 = 1'b0; haddr = 32'd0; hwdata = 32'd0;
        htrans = 2'b00; hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0;
        repeat (2) @(posedge HCLK);
        #1;
        chk("reset_ready0", {31'd0, rdy0}, 32'd1);
        chk("reset_resp0", {31'd0, resp0}, 32'd0);
        chk("reset_rdata0", rdata0, 32'd0);
        chk("reset_ready3", {31'd0, rdy3}, 32'd1);
        HRESETn = 1'b1;
        step();

        // Word write then read, no wait states
        xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, rd, rs, low);
        chk("wr10_low", 32'(low), 32'd0);
        chk("wr10_resp", {31'd0, rs}, 32'd0);
        xfer(32'h10, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("rd10_data", rd, 32'hDEADBEEF);
        chk("rd10_low", 32'(low), 32'd0);
        chk("rd10_resp", {31'd0, rs}, 32'd0);

        // Byte lane 2 merge
        xfer(32'h10, 1'b1, 3'd2, 32'h11223344, rd, rs, low);
        xfer(32'h12, 1'b1, 3'd0, 32'h00AA0000, rd, rs, low);
        xfer(32'h10, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("byte_merge", rd, 32'h11AA3344);

        // Upper halfword merge
        xfer(32'h14, 1'b1, 3'd2, 32'h55667788, rd, rs, low);
        xfer(32'h16, 1'b1, 3'd1, 32'hBEEF0000, rd, rs, low);
        xfer(32'h14, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("half_merge", rd, 32'hBEEF7788);

        // Back-to-back write then read of the same word
        hsel = 1'b1; haddr = 32'h20; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        step();
        hwdata = 32'hCAFEF00D; hwrite = 1'b0;
        step();
        hsel = 1'b0; htrans = 2'b00;
        chk("raw_ready", {31'd0, rdy}, 32'd1);
        chk("raw_data", rdata, 32'hCAFEF00D);
        step();

        // Out-of-range accesses: ERROR, no memory side effect (0x400 aliases index 0 if unchecked)
        xfer(32'h0, 1'b1, 3'd2, 32'h0BADF00D, rd, rs, low);
        xfer(32'h400, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("oor_rd_low", 32'(low), 32'd1);
        chk("oor_rd_resp", {31'd0, rs}, 32'd1);
        chk("oor_rd_data", rd, 32'd0);
        xfer(32'h400, 1'b1, 3'd2, 32'hFFFFFFFF, rd, rs, low);
        chk("oor_wr_resp", {31'd0, rs}, 32'd1);
        xfer(32'h0, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("oor_mem_kept", rd, 32'h0BADF00D);

        // Oversize transfer
        xfer(32'h8, 1'b0, 3'd3, 32'd0, rd, rs, low);
        chk("size_err_resp", {31'd0, rs}, 32'd1);
        chk("size_err_low", 32'(low), 32'd1);

        // Misaligned word write, then a read accepted in ERR2
        hsel = 1'b1; haddr = 32'h02; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        step();
        hwdata = 32'h12345678; haddr = 32'h10; hwrite = 1'b0;
        chk("err1_ready", {31'd0, rdy}, 32'd0);
        chk("err1_resp", {31'd0, resp}, 32'd1);
        step();
        chk("err2_ready", {31'd0, rdy}, 32'd1);
        chk("err2_resp", {31'd0, resp}, 32'd1);
        step();
        hsel = 1'b0; htrans = 2'b00;
        chk("after_err_ready", {31'd0, rdy}, 32'd1);
        chk("after_err_resp", {31'd0, resp}, 32'd0);
        chk("after_err_data", rdata, 32'h11AA3344);
        step();
        xfer(32'h0, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("misalign_mem_kept", rd, 32'h0BADF00D);

        // Three wait states
        sel3 = 1'b1;
        xfer(32'h8, 1'b1, 3'd2, 32'h01020304, rd, rs, low);
        chk("ws_wr_low", 32'(low), 32'd3);
        xfer(32'h8, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("ws_rd_low", 32'(low), 32'd3);
        chk("ws_rd_data", rd, 32'h01020304);
        chk("ws_rd_resp", {31'd0, rs}, 32'd0);

        // INCR4 read burst: 4 beats x 4 data-phase cycles
        xfer(32'h0, 1'b1, 3'd2, 32'hA0A0A0A0, rd, rs, low);
        xfer(32'h4, 1'b1, 3'd2, 32'hB1B1B1B1, rd, rs, low);
        xfer(32'hC, 1'b1, 3'd2, 32'hD3D3D3D3, rd, rs, low);
        bexp[0] = 32'hA0A0A0A0; bexp[1] = 32'hB1B1B1B1;
        bexp[2] = 32'h01020304; bexp[3] = 32'hD3D3D3D3;
        hsel = 1'b1; hburst = 3'b011; haddr = 32'h0; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
        step();
        cyc = 0;
        for (int b = 0; b < 4; b++) begin
            if (b < 3) begin
                haddr  = 32'(4 * (b + 1));
                htrans = 2'b11;
            end else begin
                hsel   = 1'b0;
                htrans = 2'b00;
            end
            guard = 0;
            while (rdy !== 1'b1 && guard < 40) begin
                cyc++;
                guard++;
                step();
            end
            cyc++;
            chk($sformatf("burst_beat%0d", b), rdata, bexp[b]);
            step();
        end
        chk("burst_cycles", 32'(cyc), 32'd16);
        hburst = 3'd0;

        // Reset during the wait of a write drops it
        hsel = 1'b1; haddr = 32'h8; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        step();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'hFFFF0000;
        chk("rst_wait_low", {31'd0, rdy}, 32'd0);
        step();
        HRESETn = 1'b0;
        #1;
        chk("rst_ready", {31'd0, rdy3}, 32'd1);
        chk("rst_resp", {31'd0, resp3}, 32'd0);
        chk("rst_rdata", rdata3, 32'd0);
        step();
        HRESETn = 1'b1;
        step();
        xfer(32'h8, 1'b0, 3'd2, 32'd0, rd, rs, low);
        chk("rst_write_dropped", rd, 32'h01020304);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
